// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Tracks in-flight destination registers past ID and generates
//               stall, bubble, flush, forwarding selects and a stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
  parameter int RA_W     = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  parameter int FWD_EN   = 1,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         id_valid,
  input  logic [RA_W-1:0]              id_rs,
  input  logic [RA_W-1:0]              id_rt,
  input  logic                         id_rs_used,
  input  logic                         id_rt_used,
  input  logic [RA_W-1:0]              id_rw,
  input  logic                         id_reg_wr,
  input  logic                         id_is_load,
  input  logic                         br_taken,
  output logic                         issue,
  output logic                         if_stall,
  output logic                         id_bubble,
  output logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_a_sel,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_b_sel,
  output logic [CNT_W-1:0]             stall_cycles
);

  localparam int SEL_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]           v_q;
  logic [DEPTH-1:0]           wr_q;
  logic [DEPTH-1:0]           ld_q;
  logic [DEPTH-1:0][RA_W-1:0] rw_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [CNT_W-1:0]           cnt_d;

  logic             stall_a, stall_b, hz;
  logic [SEL_W-1:0] sel_a, sel_b;

  // Scan oldest to youngest so the youngest matching entry wins.
  function automatic logic [SEL_W:0] resolve(input logic [RA_W-1:0] src,
                                             input logic            used);
    logic             stl;
    logic [SEL_W-1:0] sel;
    stl = 1'b0;
    sel = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (used && (src != '0) && v_q[k] && wr_q[k] && (rw_q[k] == src)) begin
        sel = SEL_W'(k + 1);
        stl = (FWD_EN == 0) || (ld_q[k] && (k < LOAD_LAT));
      end
    end
    if (FWD_EN == 0) sel = '0;
    return {stl, sel};
  endfunction

  always_comb begin
    {stall_a, sel_a} = resolve(id_rs, id_rs_used);
    {stall_b, sel_b} = resolve(id_rt, id_rt_used);
    hz = id_valid & (stall_a | stall_b);

    issue     = 1'b0;
    if_stall  = 1'b0;
    id_bubble = 1'b1;
    flush     = 1'b0;
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    if (br_taken) begin
      flush = 1'b1;
    end else if (hz) begin
      if_stall = 1'b1;
    end else begin
      issue     = id_valid;
      id_bubble = ~id_valid;
      fwd_a_sel = sel_a;
      fwd_b_sel = sel_b;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (if_stall && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  // Entries shift every cycle; a stalled or flushed slot enters as a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      wr_q  <= '0;
      ld_q  <= '0;
      rw_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        v_q[k]  <= v_q[k-1];
        wr_q[k] <= wr_q[k-1];
        ld_q[k] <= ld_q[k-1];
        rw_q[k] <= rw_q[k-1];
      end
      v_q[0]  <= issue;
      wr_q[0] <= issue & id_reg_wr;
      ld_q[0] <= issue & id_is_load;
      rw_q[0] <= issue ? id_rw : '0;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_cycles = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed scoreboard bench for hazard_scoreboard (forwarding
//               instance plus a stall-only instance with a 2-bit counter).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rw = '0;
  logic       id_rs_used = 1'b0, id_rt_used = 1'b0;
  logic       id_reg_wr = 1'b0, id_is_load = 1'b0, br_taken = 1'b0;

  logic       iss0, stl0, bub0, fl0, iss1, stl1, bub1, fl1;
  logic [1:0] fa0, fb0, fa1, fb1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  always #5 clk = ~clk;

  hazard_scoreboard #(.RA_W(5), .DEPTH(3), .LOAD_LAT(2), .FWD_EN(1), .CNT_W(16)) u_fwd (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rw(id_rw),
    .id_reg_wr(id_reg_wr), .id_is_load(id_is_load), .br_taken(br_taken),
    .issue(iss0), .if_stall(stl0), .id_bubble(bub0), .flush(fl0),
    .fwd_a_sel(fa0), .fwd_b_sel(fb0), .stall_cycles(cnt0));

  hazard_scoreboard #(.RA_W(5), .DEPTH(3), .LOAD_LAT(2), .FWD_EN(0), .CNT_W(2)) u_stl (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rw(id_rw),
    .id_reg_wr(id_reg_wr), .id_is_load(id_is_load), .br_taken(br_taken),
    .issue(iss1), .if_stall(stl1), .id_bubble(bub1), .flush(fl1),
    .fwd_a_sel(fa1), .fwd_b_sel(fb1), .stall_cycles(cnt1));

  typedef struct {
    bit          dut;
    logic [3:0]  ctl;   // {issue, if_stall, id_bubble, flush}
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] cnt;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  // Monitor: each cycle the driver has queued a vector, sample mid-cycle and compare.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t        e;
      logic [3:0]  a_ctl;
      logic [1:0]  a_fa, a_fb;
      logic [15:0] a_cnt;
      e = exp_q.pop_front();
      if (e.dut) begin
        a_ctl = {iss1, stl1, bub1, fl1}; a_fa = fa1; a_fb = fb1; a_cnt = {14'd0, cnt1};
      end else begin
        a_ctl = {iss0, stl0, bub0, fl0}; a_fa = fa0; a_fb = fb0; a_cnt = cnt0;
      end
      tests_run++;
      if (a_ctl !== e.ctl || a_fa !== e.fa || a_fb !== e.fb || a_cnt !== e.cnt) begin
        tests_failed++;
        $display("FAIL %s: got iss/stl/bub/fl=%b fa=%0d fb=%0d cnt=%0d, expected %b fa=%0d fb=%0d cnt=%0d",
                 e.name, a_ctl, a_fa, a_fb, a_cnt, e.ctl, e.fa, e.fb, e.cnt);
      end
    end
  end

  task automatic step(input string nm, input bit d, input logic rn, input logic v,
                      input int rs, input logic rsu, input int rt, input logic rtu,
                      input int rw, input logic wr, input logic ld, input logic br,
                      input logic [3:0] ctl, input int fa, input int fb, input int cnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rn; id_valid = v; id_rs = rs[4:0]; id_rs_used = rsu;
    id_rt = rt[4:0]; id_rt_used = rtu; id_rw = rw[4:0];
    id_reg_wr = wr; id_is_load = ld; br_taken = br;
    e.dut = d; e.ctl = ctl; e.fa = fa[1:0]; e.fb = fb[1:0]; e.cnt = cnt[15:0]; e.name = nm;
    exp_q.push_back(e);
  endtask

  // ctl encodings: {issue, if_stall, id_bubble, flush}
  localparam logic [3:0] ISS = 4'b1000;
  localparam logic [3:0] STL = 4'b0110;
  localparam logic [3:0] FLS = 4'b0011;
  localparam logic [3:0] IDL = 4'b0010;

  initial begin
    //          name        d rn v  rs rsu rt rtu rw wr ld br  ctl  fa fb cnt
    step("rst_valid",   0, 0, 1,  0, 0,  0, 0,  0, 0, 0, 0, ISS, 0, 0, 0);
    step("rst_idle",    0, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0, IDL, 0, 0, 0);
    step("add_r3",      0, 1, 1,  1, 1,  2, 1,  3, 1, 0, 0, ISS, 0, 0, 0);
    step("fwd_ex_rs",   0, 1, 1,  3, 1,  0, 0,  8, 1, 0, 0, ISS, 1, 0, 0);
    step("indep",       0, 1, 1,  9, 1, 10, 1, 11, 1, 0, 0, ISS, 0, 0, 0);
    step("lw_r4",       0, 1, 1,  1, 1,  0, 0,  4, 1, 1, 0, ISS, 0, 0, 0);
    step("ld_use_1",    0, 1, 1,  1, 0,  4, 1, 12, 1, 0, 0, STL, 0, 0, 0);
    step("ld_use_2",    0, 1, 1,  1, 0,  4, 1, 12, 1, 0, 0, STL, 0, 0, 1);
    step("ld_fwd_wr",   0, 1, 1,  1, 0,  4, 1, 12, 1, 0, 0, ISS, 0, 3, 2);
    step("wr_r7_a",     0, 1, 1,  0, 0,  0, 0,  7, 1, 0, 0, ISS, 0, 0, 2);
    step("nowr_r7",     0, 1, 1,  0, 0,  0, 0,  7, 0, 0, 0, ISS, 0, 0, 2);
    step("wr_r7_b",     0, 1, 1,  0, 0,  0, 0,  7, 1, 0, 0, ISS, 0, 0, 2);
    step("youngest",    0, 1, 1,  7, 1,  0, 0,  0, 1, 0, 0, ISS, 1, 0, 2);
    step("r0_skip",     0, 1, 1,  0, 1,  7, 1,  0, 0, 0, 0, ISS, 0, 2, 2);
    step("lw_r6",       0, 1, 1,  0, 0,  0, 0,  6, 1, 1, 0, ISS, 0, 0, 2);
    step("br_flush",    0, 1, 1,  6, 1,  0, 0,  9, 1, 0, 1, FLS, 0, 0, 2);
    step("ld_stall_r6", 0, 1, 1,  6, 1,  0, 0,  9, 1, 0, 0, STL, 0, 0, 2);
    step("rst_mid",     0, 0, 1,  6, 1,  0, 0,  9, 1, 0, 0, ISS, 0, 0, 0);
    step("add_r5",      1, 1, 1,  0, 0,  0, 0,  5, 1, 0, 0, ISS, 0, 0, 0);
    step("nofwd_1",     1, 1, 1,  5, 1,  0, 0, 13, 1, 0, 0, STL, 0, 0, 0);
    step("nofwd_2",     1, 1, 1,  5, 1,  0, 0, 13, 1, 0, 0, STL, 0, 0, 1);
    step("nofwd_3",     1, 1, 1,  5, 1,  0, 0, 13, 1, 0, 0, STL, 0, 0, 2);
    step("nofwd_iss",   1, 1, 1,  5, 1,  0, 0, 13, 1, 0, 0, ISS, 0, 0, 3);
    step("sat_1",       1, 1, 1, 13, 1,  0, 0,  1, 1, 0, 0, STL, 0, 0, 3);
    step("sat_2",       1, 1, 1, 13, 1,  0, 0,  1, 1, 0, 0, STL, 0, 0, 3);
    step("sat_3",       1, 1, 1, 13, 1,  0, 0,  1, 1, 0, 0, STL, 0, 0, 3);
    step("sat_hold",    1, 1, 1, 13, 1,  0, 0,  1, 1, 0, 0, ISS, 0, 0, 3);
    repeat (3) @(posedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d vectors left unchecked, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
